// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, FSM encoding and datapath widths for the shared ALU controller.
package alu_pkg;
    localparam int OPND_W = 4;
    localparam int RES_W  = 8;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational 4-bit ALU with zero-extended operands and 8-bit results.
module alu_core
    import alu_pkg::*;
(
    input  logic [1:0]        op,
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [RES_W-1:0]  y
);
    logic [RES_W-1:0] a8, b8;
    assign a8 = {{(RES_W-OPND_W){1'b0}}, a};
    assign b8 = {{(RES_W-OPND_W){1'b0}}, b};
    always_comb begin
        y = (op == OP_ADD) ? a8 + b8 :
            (op == OP_SUB) ? a8 - b8 :
            (op == OP_AND) ? a8 & b8 : a8 | b8;
    end
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin arbiter and IDLE/EXEC/RESP sequencer sharing one alu_core
// between two requesters, with a registered result and a completed-operation counter.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [2*NUM_REQ-1:0]      req_op,
    input  logic [OPND_W*NUM_REQ-1:0] req_a,
    input  logic [OPND_W*NUM_REQ-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [RES_W-1:0]          rsp_data,
    output logic                      rsp_id,
    output logic                      busy,
    output logic [CNT_W-1:0]          op_count
);
    state_t            state_q, state_d;
    logic              last_grant_q, id_q, busy_q, gnt, accept;
    logic [1:0]        op_q;
    logic [OPND_W-1:0] a_q, b_q;
    logic [RES_W-1:0]  y, rsp_data_q;
    logic [CNT_W-1:0]  op_count_q;

    // Contention goes to the requester that did not win last; a lone requester always wins.
    assign gnt       = (&req_valid) ? ~last_grant_q : req_valid[1];
    assign accept    = (state_q == IDLE) && (|req_valid) && !rst;
    assign req_ready = {gnt, ~gnt} & {NUM_REQ{accept}};
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = id_q;
    assign busy      = busy_q;
    assign op_count  = op_count_q;

    always_comb begin
        state_d = (state_q == IDLE) ? ((|req_valid) ? EXEC : IDLE) :
                  (state_q == EXEC) ? RESP :
                  (rsp_ready ? IDLE : RESP);
    end

    alu_core u_alu (.op(op_q), .a(a_q), .b(b_q), .y(y));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            op_q         <= 2'b00;
            a_q          <= '0;
            b_q          <= '0;
            rsp_data_q   <= '0;
            busy_q       <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            if (accept) begin
                last_grant_q <= gnt;
                id_q         <= gnt;
                op_q         <= gnt ? req_op[3:2] : req_op[1:0];
                a_q          <= gnt ? req_a[2*OPND_W-1:OPND_W] : req_a[OPND_W-1:0];
                b_q          <= gnt ? req_b[2*OPND_W-1:OPND_W] : req_b[OPND_W-1:0];
            end
            if (state_q == EXEC) rsp_data_q <= y;
            if (state_q == RESP && rsp_ready) op_count_q <= op_count_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed self-checking bench for alu_share_ctrl.
module tb_alu_share_ctrl;
    logic       clk = 1'b0, rst = 1'b1;
    logic [1:0] req_valid = '0, req_ready;
    logic [3:0] req_op = '0;
    logic [7:0] req_a = '0, req_b = '0;
    logic       rsp_valid, rsp_ready = 1'b0, rsp_id, busy;
    logic [7:0] rsp_data, op_count;
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    alu_share_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy),
        .op_count(op_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete operation from IDLE with rsp_ready held high; req_valid stays asserted.
    task automatic run_op(input string tag, input logic [1:0] v, input logic exp_id,
                          input logic [7:0] exp_data, input logic [7:0] exp_cnt);
        req_valid = v;
        rsp_ready = 1'b1;
        #1;
        chk({tag, ".grant"}, 32'(req_ready), exp_id ? 32'h2 : 32'h1);
        tick();
        chk({tag, ".exec_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, ".exec_busy"}, 32'(busy), 32'h1);
        chk({tag, ".exec_ready"}, 32'(req_ready), 32'h0);
        tick();
        chk({tag, ".resp_valid"}, 32'(rsp_valid), 32'h1);
        chk({tag, ".resp_data"}, 32'(rsp_data), 32'(exp_data));
        chk({tag, ".resp_id"}, 32'(rsp_id), 32'(exp_id));
        chk({tag, ".resp_ready"}, 32'(req_ready), 32'h0);
        tick();
        chk({tag, ".count"}, 32'(op_count), 32'(exp_cnt));
        chk({tag, ".idle_valid"}, 32'(rsp_valid), 32'h0);
    endtask

    initial begin
        req_valid = 2'b11;
        tick();
        tick();
        #1;
        chk("rst.req_ready", 32'(req_ready), 32'h0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst.rsp_data", 32'(rsp_data), 32'h0);
        chk("rst.rsp_id", 32'(rsp_id), 32'h0);
        chk("rst.busy", 32'(busy), 32'h0);
        chk("rst.op_count", 32'(op_count), 32'h0);
        req_valid = '0;
        rst = 1'b0;
        tick();

        // add F+F on requester 0
        req_op = 4'b00_00; req_a = 8'h0F; req_b = 8'h0F;
        run_op("add", 2'b01, 1'b0, 8'h1E, 8'd1);
        // sub 3-5 on requester 1
        req_op = 4'b01_00; req_a = 8'h30; req_b = 8'h50;
        run_op("sub", 2'b10, 1'b1, 8'hFE, 8'd2);

        // contention: r0 adds 1+2, r1 subs 9-2; last grant was 1 so r0 goes first
        req_op = 4'b01_00; req_a = 8'h91; req_b = 8'h22;
        run_op("rr0", 2'b11, 1'b0, 8'h03, 8'd3);
        run_op("rr1", 2'b11, 1'b1, 8'h07, 8'd4);
        run_op("rr2", 2'b11, 1'b0, 8'h03, 8'd5);
        run_op("rr3", 2'b11, 1'b1, 8'h07, 8'd6);
        req_valid = '0;

        // backpressure with AND C&A on requester 0
        req_op = 4'b00_10; req_a = 8'h0C; req_b = 8'h0A;
        req_valid = 2'b01; rsp_ready = 1'b0;
        #1;
        chk("bp.grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b11;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp.valid", 32'(rsp_valid), 32'h1);
            chk("bp.data", 32'(rsp_data), 32'h08);
            chk("bp.id", 32'(rsp_id), 32'h0);
            chk("bp.req_ready", 32'(req_ready), 32'h0);
            chk("bp.count", 32'(op_count), 32'd6);
            tick();
        end
        req_valid = '0; rsp_ready = 1'b1;
        tick();
        chk("bp.release_count", 32'(op_count), 32'd7);
        chk("bp.release_valid", 32'(rsp_valid), 32'h0);
        tick();
        chk("bp.single_count", 32'(op_count), 32'd7);

        // OR C|A on requester 1
        req_op = 4'b11_00; req_a = 8'hC0; req_b = 8'hA0;
        run_op("or", 2'b10, 1'b1, 8'h0E, 8'd8);
        req_valid = '0;

        // reset in EXEC: requester 1 wins alone, then reset restores last_grant to 1
        req_op = 4'b00_00; req_a = 8'h11; req_b = 8'h11;
        req_valid = 2'b10;
        tick();
        chk("mid.exec_busy", 32'(busy), 32'h1);
        req_valid = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid.valid", 32'(rsp_valid), 32'h0);
        chk("mid.busy", 32'(busy), 32'h0);
        chk("mid.count", 32'(op_count), 32'h0);
        tick();
        chk("mid.no_resp", 32'(rsp_valid), 32'h0);
        run_op("mid.rr", 2'b11, 1'b0, 8'h02, 8'd1);
        req_valid = '0;

        // counter wrap: r0 adds 1+(i%16)
        for (int i = 2; i <= 255; i++) begin
            req_a = 8'h01; req_b = 8'(i % 16);
            run_op("wrap", 2'b01, 1'b0, 8'(1 + i % 16), 8'(i));
        end
        chk("wrap.255", 32'(op_count), 32'd255);
        req_a = 8'h0F; req_b = 8'h01;
        run_op("wrap.last", 2'b01, 1'b0, 8'h10, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencing and arbitration controller that shares one 4-bit ALU datapath between two requesters. Each requester issues operations over a valid/ready request channel. The block grants round-robin, latches operands, evaluates them on the shared ALU core for one cycle and returns the registered 8-bit result with the requester ID over a shared valid/ready response channel. It sits between the tile's control logic and the ALU core and is the only block that drives the ALU inputs.

## Interface

- `NUM_REQ`, 2: number of requesters (fixed at 2; the ID is 1 bit).
- `CNT_W`, 8: width of the completed-operation counter.

Ports:

- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  2  bit i: requester i presents an operation.
- `req_ready`  out  2  bit i: requester i's operation is accepted this cycle.
- `req_op`  in  2x2  per-requester opcode: 00 add, 01 sub, 10 and, 11 or.
- `req_a`  in  2x4  per-requester operand A.
- `req_b`  in  2x4  per-requester operand B.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_data`  out  8  ALU result.
- `rsp_id`  out  1  index of the requester that issued the operation.
- `busy`  out  1  high when not in IDLE.
- `op_count`  out  CNT_W  number of completed responses; wraps.

## Operation

- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - If any `req_valid` bit is set, grant one requester and assert only that requester's `req_ready` bit, in the same cycle (combinational from state, `req_valid` and `last_grant`).
  - Latch that requester's op, a, b and id. Next state is EXEC.
- Arbitration is round-robin:
  - With both requesters valid, grant the one that is not `last_grant`.
  - With a single requester valid, grant it regardless of `last_grant`.
  - `last_grant` updates on every grant and resets to 1, so requester 0 wins the first contention.
- EXEC:
  - The latched operands drive the ALU core.
  - The result is registered into `rsp_data` at the end of the cycle.
  - Next state is RESP unconditionally.
- RESP:
  - `rsp_valid`=1. `rsp_data` and `rsp_id` are held stable.
  - On `rsp_valid`&`rsp_ready`: increment `op_count` (modulo 2^CNT_W) and go to IDLE.
  - Without `rsp_ready`, stay in RESP indefinitely.
- `req_ready` is 0 in EXEC and RESP. There is no request buffering.
- Requesters must hold `req_op`, `req_a` and `req_b` stable while `req_valid` is high and not yet accepted. Dropping `req_valid` before acceptance is allowed and withdraws the request.
- Arithmetic (ALU core):
  - Operands are zero-extended to 8 bits and all four results are 8-bit.
  - add: 4'hF+4'hF = 8'h1E.
  - sub wraps in 8-bit two's complement: 3-5 = 8'hFE.
  - and/or: upper nibble is 0.

## Timing

- Reset values: `req_ready`=0 (forced 0 while `rst`=1), `rsp_valid`=0, `rsp_data`=8'h00, `rsp_id`=0, `busy`=0, `op_count`=0, `last_grant`=1, state IDLE.
- Latency: accept in cycle N, EXEC in N+1, `rsp_valid` high in N+2.
- Minimum issue interval is 3 cycles, reached when `rsp_ready` is held high. The next accept can occur at N+3.
- Simultaneous events:
  - `rsp_ready` high in the same cycle RESP is entered completes the response in that cycle.
  - New requests are not accepted in the RESP-completing cycle; they are accepted in the following IDLE cycle.
- Reset mid-operation (EXEC or RESP) aborts the operation without a response: `op_count` does not increment and `rsp_valid` drops in the next cycle.
- `op_count` wraps from 2^CNT_W-1 to 0 with no flag.
- `busy` is registered and equals (state != IDLE).

## Structure

- Shared package `alu_pkg`:
  - opcode constants `OP_ADD`=2'b00, `OP_SUB`=2'b01, `OP_AND`=2'b10, `OP_OR`=2'b11.
  - FSM state encoding (IDLE=0, EXEC=1, RESP=2).
  - operand width 4 and result width 8.
- One sub-module, `alu_core`: combinational, ports `op[1:0]`, `a[3:0]`, `b[3:0]` and `y[7:0]`, implementing the arithmetic rules above. It is instantiated once.
- The controller (FSM, arbiter, operand latches, result register and counter) lives in `alu_share_ctrl`.

## Test plan

- Single add on requester 0:
  - Stimulus: after reset, requester 0 drives op=00, a=F, b=F, `rsp_ready`=1.
  - Required: `req_ready`[0] high at cycle 0; `rsp_valid` at cycle 2 with `rsp_data`=8'h1E and `rsp_id`=0; `op_count`=1.
- Subtraction wrap:
  - Stimulus: requester 1 drives op=01, a=3, b=5.
  - Required: `rsp_data`=8'hFE and `rsp_id`=1.
- Round-robin under contention:
  - Stimulus: both requesters held valid continuously with `rsp_ready`=1.
  - Required: grants alternate 0,1,0,1; one response every 3 cycles; `op_count`=4 after 4 responses.
- Backpressure:
  - Stimulus: `rsp_ready`=0 for 5 cycles, then 1.
  - Required: `rsp_data` and `rsp_id` stable and `req_ready`=0 throughout; exactly one response on release.
- Reset mid-operation:
  - Stimulus: assert `rst` in the EXEC cycle.
  - Required: next cycle state IDLE, `rsp_valid`=0, `op_count` unchanged at 0, `last_grant`=1.
- AND/OR and counter wrap:
  - Stimulus: op=10 with a=C, b=A, then op=11 with a=C, b=A; then run 256 operations.
  - Required: results 8'h08 and 8'h0E; `op_count` returns to 0.
